// File: rtl/chacha_pkg.sv
// Shared widths, state encoding and keystream word selection for the ChaCha stream XOR block.
package chacha_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 512;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int IDX_W           = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Word i of a keystream block lives at bits [WORD_W*i +: WORD_W].
    function automatic logic [WORD_W-1:0] ks_word(
        input logic [BLOCK_W-1:0] block,
        input logic [IDX_W-1:0]   idx
    );
        return block[WORD_W*idx +: WORD_W];
    endfunction

endpackage

// File: rtl/chacha_ks_buffer.sv
// Holds one 512-bit keystream block and walks through its sixteen words.
module chacha_ks_buffer
    import chacha_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] ks_block,
    input  logic               ks_valid,
    input  logic               advance,
    input  logic               last,
    output logic               ks_ready,
    output logic               full,
    output logic [WORD_W-1:0]  word
);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [BLOCK_W-1:0] block_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= EMPTY;
            idx_reg   <= '0;
            block_reg <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (ks_valid) begin
                        block_reg <= ks_block;
                        idx_reg   <= '0;
                        state_reg <= FULL;
                    end
                end
                FULL: begin
                    if (advance) begin
                        // End of message discards the rest of the block; the next one uses a new counter.
                        if (last || idx_reg == IDX_W'(WORDS_PER_BLOCK - 1)) begin
                            state_reg <= EMPTY;
                            idx_reg   <= '0;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign ks_ready = (state_reg == EMPTY);
    assign full     = (state_reg == FULL);
    assign word     = ks_word(block_reg, idx_reg);

endmodule

// File: rtl/chacha_stream_xor.sv
// XORs a data-word stream with buffered ChaCha20 keystream words, one word per cycle.
// Optional byte-keep ports are enabled by defining CHACHA_XOR_KEEP_EN.
module chacha_stream_xor
    import chacha_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter int OUT_WIDTH = BLOCK_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OUT_WIDTH-1:0] ks_block,
    input  logic                 ks_valid,
    output logic                 ks_ready,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 data_in_valid,
    input  logic                 data_in_last,
`ifdef CHACHA_XOR_KEEP_EN
    input  logic [WIDTH/8-1:0]   data_in_keep,
    output logic [WIDTH/8-1:0]   data_out_keep,
`endif
    output logic                 data_in_ready,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_out_valid,
    output logic                 data_out_last,
    input  logic                 data_out_ready
);

    localparam int BYTES = WIDTH / 8;

    logic             full;
    logic             accept;
    logic [WIDTH-1:0] ks_cur;
    logic [WIDTH-1:0] mixed;
    logic [WIDTH-1:0] masked;
    logic [BYTES-1:0] keep_eff;
    logic [WIDTH-1:0] data_out_reg;
    logic             data_out_valid_reg;
    logic             data_out_last_reg;

    chacha_ks_buffer u_buffer (
        .clk      (clk),
        .reset    (reset),
        .ks_block (ks_block),
        .ks_valid (ks_valid),
        .advance  (accept),
        .last     (data_in_last),
        .ks_ready (ks_ready),
        .full     (full),
        .word     (ks_cur)
    );

    assign data_in_ready = full && (!data_out_valid_reg || data_out_ready);
    assign accept        = data_in_valid && data_in_ready;
    assign mixed         = data_in ^ ks_cur;

`ifdef CHACHA_XOR_KEEP_EN
    assign keep_eff = data_in_keep;
`else
    assign keep_eff = '1;
`endif

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte_mask
            assign masked[8*gi +: 8] = keep_eff[gi] ? mixed[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_reg       <= '0;
            data_out_valid_reg <= 1'b0;
            data_out_last_reg  <= 1'b0;
        end else if (accept) begin
            data_out_reg       <= masked;
            data_out_valid_reg <= 1'b1;
            data_out_last_reg  <= data_in_last;
        end else if (data_out_ready) begin
            data_out_valid_reg <= 1'b0;
        end
    end

`ifdef CHACHA_XOR_KEEP_EN
    logic [BYTES-1:0] data_out_keep_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_keep_reg <= '0;
        end else if (accept) begin
            data_out_keep_reg <= keep_eff;
        end
    end

    assign data_out_keep = data_out_keep_reg;
`endif

    assign data_out       = data_out_reg;
    assign data_out_valid = data_out_valid_reg;
    assign data_out_last  = data_out_last_reg;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Bench for chacha_stream_xor: directed scenarios plus random traffic against a word-level model.
module tb_chacha_stream_xor;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] ks_block;
    logic         ks_valid;
    logic         ks_ready;
    logic [31:0]  data_in;
    logic         data_in_valid;
    logic         data_in_last;
    logic [3:0]   keep_in;
    logic         data_in_ready;
    logic [31:0]  data_out;
    logic         data_out_valid;
    logic         data_out_last;
    logic         data_out_ready;
`ifdef CHACHA_XOR_KEEP_EN
    logic [3:0]   data_out_keep;
`endif

    int total = 0;
    int bad   = 0;

    chacha_stream_xor dut (
        .clk            (clk),
        .reset          (reset),
        .ks_block       (ks_block),
        .ks_valid       (ks_valid),
        .ks_ready       (ks_ready),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_last   (data_in_last),
`ifdef CHACHA_XOR_KEEP_EN
        .data_in_keep   (keep_in),
        .data_out_keep  (data_out_keep),
`endif
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_last  (data_out_last),
        .data_out_ready (data_out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: the held block as 16 words, a read position, and the output register.
    bit          m_full;
    int          m_idx;
    logic [31:0] m_words [16];
    bit          m_ov;
    logic [31:0] m_out;
    bit          m_last;
    logic [3:0]  m_keep;

    always @(negedge clk) begin
        bit          exp_ks_rdy;
        bit          exp_din_rdy;
        logic [31:0] x;
        if (reset) begin
            m_full = 0; m_idx = 0; m_ov = 0; m_out = '0; m_last = 0; m_keep = '0;
        end
        exp_ks_rdy  = !m_full;
        exp_din_rdy = m_full && (!m_ov || data_out_ready);
        chk("ks_ready", 32'(ks_ready), 32'(exp_ks_rdy));
        chk("data_in_ready", 32'(data_in_ready), 32'(exp_din_rdy));
        chk("data_out_valid", 32'(data_out_valid), 32'(m_ov));
        if (m_ov || reset) begin
            chk("data_out", data_out, m_out);
            chk("data_out_last", 32'(data_out_last), 32'(m_last));
`ifdef CHACHA_XOR_KEEP_EN
            chk("data_out_keep", 32'(data_out_keep), 32'(m_keep));
`endif
        end
        if (!reset) begin
            if (ks_valid && exp_ks_rdy) begin
                m_full = 1;
                m_idx  = 0;
                for (int k = 0; k < 16; k++) m_words[k] = ks_block[32*k +: 32];
            end
            if (data_in_valid && exp_din_rdy) begin
                x = data_in ^ m_words[m_idx];
                for (int b = 0; b < 4; b++) if (!keep_in[b]) x[8*b +: 8] = 8'h00;
                m_out  = x;
                m_ov   = 1;
                m_last = data_in_last;
                m_keep = keep_in;
                if (data_in_last || m_idx == 15) m_full = 0;
                m_idx = (m_idx + 1) % 16;
            end else if (data_out_ready) begin
                m_ov = 0;
            end
        end
    end

    function automatic logic [511:0] make_block(input logic [31:0] w0);
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
        b[31:0] = w0;
        return b;
    endfunction

    task automatic load(input logic [511:0] b);
        bit ok;
        int n = 0;
        ks_block = b;
        ks_valid = 1'b1;
        do begin
            @(negedge clk); ok = ks_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 50);
        if (!ok) begin
            total++; bad++;
            $display("FAIL load_timeout: ks_ready stayed 0 expected 1 within 50 cycles");
        end
        ks_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input logic l, input logic [3:0] k);
        bit ok;
        int n = 0;
        data_in       = w;
        data_in_valid = 1'b1;
        data_in_last  = l;
        keep_in       = k;
        do begin
            @(negedge clk); ok = data_in_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 50);
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: data_in_ready stayed 0 expected 1 within 50 cycles");
        end
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        keep_in       = 4'hF;
    endtask

    task automatic chk_reset_values(input string tag);
        @(negedge clk);
        chk({tag, "_ks_ready"}, 32'(ks_ready), 32'd1);
        chk({tag, "_data_in_ready"}, 32'(data_in_ready), 32'd0);
        chk({tag, "_data_out"}, data_out, 32'h0);
        chk({tag, "_data_out_valid"}, 32'(data_out_valid), 32'd0);
        chk({tag, "_data_out_last"}, 32'(data_out_last), 32'd0);
    endtask

    initial begin
        logic [511:0] b;
        logic [31:0]  w1;
        reset = 1'b1; ks_block = '0; ks_valid = 1'b0;
        data_in = '0; data_in_valid = 1'b0; data_in_last = 1'b0;
        keep_in = 4'hF; data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_values("reset");
        @(posedge clk); #1;

        // RFC 8439 2.4.2 block 1: keystream word 0 = 0xf3514f22, "Ladi" -> 0x9a352e6e.
        load(make_block(32'hf3514f22));
        send(32'h6964614c, 1'b0, 4'hF);
        @(negedge clk);
        chk("rfc_ladi_data_out", data_out, 32'h9a352e6e);
        chk("rfc_ladi_valid", 32'(data_out_valid), 32'd1);
        @(posedge clk); #1;
        for (int i = 1; i < 16; i++) send(32'h0, 1'b0, 4'hF);
        @(negedge clk);
        chk("exhaust_ks_ready", 32'(ks_ready), 32'd1);
        chk("exhaust_data_in_ready", 32'(data_in_ready), 32'd0);
        @(posedge clk); #1;

        // Early end of message on word 5, then the next block starts at word 0.
        load(make_block($urandom));
        for (int i = 0; i < 6; i++) send($urandom, (i == 5), 4'hF);
        @(negedge clk);
        chk("early_last_ks_ready", 32'(ks_ready), 32'd1);
        @(posedge clk); #1;
        b = make_block(32'h0badf00d);
        load(b);
        send(32'ha5a5a5a5, 1'b0, 4'hF);
        @(negedge clk);
        chk("next_msg_word0", data_out, 32'ha5a5a5a5 ^ b[31:0]);
        @(posedge clk); #1;

        // Backpressure for four cycles while the next word waits.
        w1 = $urandom;
        send(w1, 1'b0, 4'hF);
        data_out_ready = 1'b0;
        data_in = 32'h13579bdf; data_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_data_in_ready", 32'(data_in_ready), 32'd0);
            chk("bp_data_out_held", data_out, w1 ^ b[63:32]);
            @(posedge clk); #1;
        end
        data_out_ready = 1'b1;
        send(32'h13579bdf, 1'b0, 4'hF);
        @(negedge clk);
        chk("bp_next_word", data_out, 32'h13579bdf ^ b[95:64]);
        @(posedge clk); #1;
        send($urandom, 1'b1, 4'hF);

        // Reset mid-message at idx 7.
        load(make_block($urandom));
        for (int i = 0; i < 7; i++) send($urandom, 1'b0, 4'hF);
        reset = 1'b1;
        chk_reset_values("midreset");
        @(posedge clk); #1 reset = 1'b0;
        b = make_block(32'hcafe1234);
        load(b);
        send(32'h00ff00ff, 1'b0, 4'hF);
        @(negedge clk);
        chk("after_reset_word0", data_out, 32'h00ff00ff ^ b[31:0]);
        @(posedge clk); #1;
        send($urandom, 1'b1, 4'hF);

`ifdef CHACHA_XOR_KEEP_EN
        load(make_block(32'h12345678));
        send(32'hffffffff, 1'b1, 4'b0011);
        @(negedge clk);
        chk("keep_data_out", data_out, 32'h0000a987);
        chk("keep_data_out_keep", 32'(data_out_keep), 32'h3);
        @(posedge clk); #1;
`endif

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 16; k++) ks_block[32*k +: 32] = $urandom;
            ks_valid       = ($urandom_range(3) == 0);
            data_in        = $urandom;
            data_in_valid  = ($urandom_range(3) != 0);
            data_in_last   = ($urandom_range(7) == 0);
`ifdef CHACHA_XOR_KEEP_EN
            keep_in        = data_in_last ? 4'($urandom) : 4'hF;
`else
            keep_in        = 4'hF;
`endif
            data_out_ready = ($urandom_range(3) != 0);
            reset          = ($urandom_range(699) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; ks_valid = 1'b0; data_in_valid = 1'b0;
        data_in_last = 1'b0; keep_in = 4'hF; data_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
